// File: rtl/inst_mem_pkg.sv
// Shared types and widths for the instruction-memory responder.
// The last-instruction buffer is compiled in only when INST_BUF_EN is defined.
package inst_mem_pkg;
  typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, DONE} state_t;

  localparam int HALF_W = 16;
  localparam int INST_W = 32;
  localparam int WAIT_W = 3;
  localparam int TAG_W  = 30;
endpackage

// File: rtl/inst_line_buffer.sv
// One-entry last-instruction buffer (tag = pc[31:2]); built only under INST_BUF_EN.
// Lookup is combinational so a hit can be answered in the request cycle.
`ifdef INST_BUF_EN
module inst_line_buffer
  import inst_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [INST_W-1:0] i_wr_data,
  input  logic [TAG_W-1:0]  i_lk_tag,
  output logic              o_hit,
  output logic [INST_W-1:0] o_data
);
  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [INST_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_wr_en) begin
      r_valid <= 1'b1;
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lk_tag);
  assign o_data = r_data;
endmodule
`endif

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: assembles a 32-bit instruction from two 16-bit SRAM beats.
// Optional one-entry hit buffer enabled by the INST_BUF_EN macro.
module inst_mem_responder
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [31:0]       pc,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              inst_valid,
  output logic              freeze,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata
);
  state_t              r_state;
  state_t              w_state_next;
  logic [WAIT_W-1:0]   r_wcnt;
  logic [WAIT_W-1:0]   w_wcnt_next;
  logic [ADDR_W-2:0]   r_addr;
  logic [HALF_W-1:0]   r_lo;
  logic [INST_W-1:0]   r_inst;
  logic                w_start;
  logic                w_lat_lo;
  logic                w_lat_hi;
  logic                w_last;
  logic                w_hit;
  logic [INST_W-1:0]   w_hit_data;
  logic                w_unused_pc;

  assign w_last = (r_wcnt == WAIT_W'(WAIT_CYCLES));

`ifdef INST_BUF_EN
  logic [TAG_W-1:0] r_tag;
  logic             w_buf_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag <= '0;
    end else if (w_start) begin
      r_tag <= pc[31:2];
    end
  end

  // Written as DONE is entered; a flushed fetch never reaches this point.
  inst_line_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_lat_hi),
    .i_wr_tag  (r_tag),
    .i_wr_data ({mem_rdata, r_lo}),
    .i_lk_tag  (pc[31:2]),
    .o_hit     (w_buf_hit),
    .o_data    (w_hit_data)
  );

  assign w_hit       = req && w_buf_hit && (r_state == IDLE);
  assign w_unused_pc = ^pc[1:0];
`else
  assign w_hit       = 1'b0;
  assign w_hit_data  = '0;
  assign w_unused_pc = ^{pc[31:ADDR_W+1], pc[1:0]};
`endif

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_start      = 1'b0;
    w_lat_lo     = 1'b0;
    w_lat_hi     = 1'b0;
    freeze       = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    inst_valid   = 1'b0;
    instruction  = r_inst;
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          inst_valid  = 1'b1;
          instruction = w_hit_data;
        end else if (req) begin
          freeze       = 1'b1;
          w_start      = 1'b1;
          w_wcnt_next  = '0;
          w_state_next = RD_LO;
        end
      end
      RD_LO: begin
        mem_addr = {r_addr, 1'b0};
        if (flush) begin
          w_wcnt_next  = '0;
          w_state_next = IDLE;
        end else begin
          mem_rd = 1'b1;
          freeze = 1'b1;
          if (w_last) begin
            w_lat_lo     = 1'b1;
            w_wcnt_next  = '0;
            w_state_next = RD_HI;
          end else begin
            w_wcnt_next = r_wcnt + 1'b1;
          end
        end
      end
      RD_HI: begin
        mem_addr = {r_addr, 1'b1};
        if (flush) begin
          w_wcnt_next  = '0;
          w_state_next = IDLE;
        end else begin
          mem_rd = 1'b1;
          freeze = 1'b1;
          if (w_last) begin
            w_lat_hi     = 1'b1;
            w_wcnt_next  = '0;
            w_state_next = DONE;
          end else begin
            w_wcnt_next = r_wcnt + 1'b1;
          end
        end
      end
      DONE: begin
        inst_valid   = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_lo    <= '0;
      r_inst  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
      if (w_start) begin
        r_addr <= pc[ADDR_W:2];
      end
      if (w_lat_lo) begin
        r_lo <= mem_rdata;
      end
      if (w_lat_hi) begin
        r_inst <= {mem_rdata, r_lo};
      end
    end
  end
endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances).
// Buffer-hit expectations switch on the INST_BUF_EN macro.
module tb_inst_mem_responder;
  logic        clk;
  logic        rst;
  logic        req, flush;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        inst_valid, freeze, mem_rd;
  logic [15:0] mem_addr, mem_rdata, rdata_q;
  logic        req0, flush0;
  logic [31:0] pc0;
  logic [31:0] instruction0;
  logic        inst_valid0, freeze0, mem_rd0;
  logic [15:0] mem_addr0, mem_rdata0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    case (a)
      16'h0004: return 16'hBEEF;
      16'h0005: return 16'hDEAD;
      16'h0006: return 16'h5678;
      16'h0007: return 16'h1234;
      16'h0008: return 16'h1111;
      16'h0009: return 16'h2222;
      16'h0010: return 16'hAAAA;
      16'h0011: return 16'h5555;
      default:  return 16'hF00D;
    endcase
  endfunction

  // One-cycle SRAM for the WAIT_CYCLES=1 instance, zero-latency for the other.
  always @(posedge clk) rdata_q <= sram_rd(mem_addr);
  assign mem_rdata  = rdata_q;
  assign mem_rdata0 = sram_rd(mem_addr0);

  inst_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .pc(pc), .flush(flush),
    .instruction(instruction), .inst_valid(inst_valid), .freeze(freeze),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  inst_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .pc(pc0), .flush(flush0),
    .instruction(instruction0), .inst_valid(inst_valid0), .freeze(freeze0),
    .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_rdata(mem_rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_done(output bit seen, output logic [31:0] data);
    seen = 1'b0;
    data = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        data = instruction;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instruction got=%h exp=%h", instruction, 32'h0); end
    checks++; if ({inst_valid, freeze, mem_rd} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {inst_valid, freeze, mem_rd}); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if ({inst_valid0, freeze0, mem_rd0} !== 3'b000) begin errors++; $display("FAIL reset_flags_w0 got=%b exp=000", {inst_valid0, freeze0, mem_rd0}); end
    rst = 1'b1;
    @(posedge clk); #1;
    $display("reset: released");
  endtask

  task automatic test_miss();
    logic [15:0] exp_ad;
    logic [2:0]  exp_f;
    req = 1'b1; pc = 32'h0000_0008;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      exp_f  = {(c <= 4) ? 1'b1 : 1'b0, (c >= 1 && c <= 4) ? 1'b1 : 1'b0, (c == 5) ? 1'b1 : 1'b0};
      exp_ad = (c == 1 || c == 2) ? 16'h0004 : (c == 3 || c == 4) ? 16'h0005 : 16'h0000;
      checks++; if ({freeze, mem_rd, inst_valid} !== exp_f) begin errors++; $display("FAIL miss_flags cyc=%0d got=%b exp=%b", c, {freeze, mem_rd, inst_valid}, exp_f); end
      checks++; if (mem_addr !== exp_ad) begin errors++; $display("FAIL miss_addr cyc=%0d got=%h exp=%h", c, mem_addr, exp_ad); end
      if (c == 5) begin
        checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_data got=%h exp=%h", instruction, 32'hDEAD_BEEF); end
      end
      @(posedge clk); #1;
      req = 1'b0;
    end
    $display("miss: pc=%h instruction=%h", 32'h8, instruction);
  endtask

  task automatic test_buffer();
    bit seen;
    logic [31:0] d;
    req = 1'b1; pc = 32'h0000_0008;
    @(negedge clk);
`ifdef INST_BUF_EN
    checks++; if ({inst_valid, freeze, mem_rd} !== 3'b100) begin errors++; $display("FAIL hit_flags got=%b exp=100", {inst_valid, freeze, mem_rd}); end
    checks++; if (instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL hit_data got=%h exp=%h", instruction, 32'hDEAD_BEEF); end
    @(posedge clk); #1; req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_rd, freeze, inst_valid} !== 3'b000) begin errors++; $display("FAIL hit_no_access got=%b exp=000", {mem_rd, freeze, inst_valid}); end
    @(posedge clk); #1;
`else
    checks++; if ({inst_valid, freeze} !== 2'b01) begin errors++; $display("FAIL refetch_miss got=%b exp=01", {inst_valid, freeze}); end
    @(posedge clk); #1; req = 1'b0;
    wait_done(seen, d);
    checks++; if (!seen || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL refetch_data seen=%0d got=%h exp=%h", seen, d, 32'hDEAD_BEEF); end
    @(posedge clk); #1;
`endif
    req = 1'b1; pc = 32'h0000_000C;
    @(negedge clk);
    checks++; if ({inst_valid, freeze} !== 2'b01) begin errors++; $display("FAIL other_pc_miss got=%b exp=01", {inst_valid, freeze}); end
    @(posedge clk); #1; req = 1'b0;
    wait_done(seen, d);
    checks++; if (!seen || d !== 32'h1234_5678) begin errors++; $display("FAIL other_pc_data seen=%0d got=%h exp=%h", seen, d, 32'h1234_5678); end
    @(posedge clk); #1;
    $display("buffer: pc=%h instruction=%h", 32'hC, d);
  endtask

  task automatic test_flush();
    req = 1'b1; pc = 32'h0000_0020;
    @(posedge clk); #1; req = 1'b0;
    repeat (2) @(posedge clk);
    #1; flush = 1'b1;
    @(negedge clk);
    checks++; if ({mem_rd, freeze, inst_valid} !== 3'b000) begin errors++; $display("FAIL flush_cycle got=%b exp=000", {mem_rd, freeze, inst_valid}); end
    @(posedge clk); #1; flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if ({mem_rd, freeze, inst_valid} !== 3'b000) begin errors++; $display("FAIL flush_idle cyc=%0d got=%b exp=000", c, {mem_rd, freeze, inst_valid}); end
      checks++; if (instruction !== 32'h1234_5678) begin errors++; $display("FAIL flush_hold cyc=%0d got=%h exp=%h", c, instruction, 32'h1234_5678); end
      @(posedge clk); #1;
    end
`ifdef INST_BUF_EN
    req = 1'b1; pc = 32'h0000_000C;
    @(negedge clk);
    checks++; if ({inst_valid, freeze} !== 2'b10 || instruction !== 32'h1234_5678) begin errors++; $display("FAIL flush_keeps_buffer got=%b/%h exp=10/%h", {inst_valid, freeze}, instruction, 32'h1234_5678); end
    @(posedge clk); #1; req = 1'b0;
`endif
    $display("flush: instruction=%h", instruction);
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [31:0] d;
    req = 1'b1; pc = 32'h0000_0020;
    @(posedge clk); #1; req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0011) begin errors++; $display("FAIL pre_reset_rd_hi got=%b/%h exp=1/0011", mem_rd, mem_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({inst_valid, freeze, mem_rd} !== 3'b000) begin errors++; $display("FAIL async_reset_flags got=%b exp=000", {inst_valid, freeze, mem_rd}); end
    checks++; if (instruction !== 32'h0 || mem_addr !== 16'h0) begin errors++; $display("FAIL async_reset_data got=%h/%h exp=0/0", instruction, mem_addr); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if ({freeze, mem_rd, inst_valid} !== 3'b000) begin errors++; $display("FAIL post_reset_idle got=%b exp=000", {freeze, mem_rd, inst_valid}); end
    @(posedge clk); #1;
    req = 1'b1; pc = 32'h0000_000C;
    @(negedge clk);
    checks++; if ({inst_valid, freeze} !== 2'b01) begin errors++; $display("FAIL post_reset_miss got=%b exp=01", {inst_valid, freeze}); end
    @(posedge clk); #1; req = 1'b0;
    wait_done(seen, d);
    checks++; if (!seen || d !== 32'h1234_5678) begin errors++; $display("FAIL post_reset_data seen=%0d got=%h exp=%h", seen, d, 32'h1234_5678); end
    @(posedge clk); #1;
    $display("reset_mid: refetch instruction=%h", d);
  endtask

  task automatic test_misaligned();
    req = 1'b1; pc = 32'h0000_000B;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        checks++; if (mem_addr !== ((c <= 2) ? 16'h0004 : 16'h0005)) begin errors++; $display("FAIL misaligned_addr cyc=%0d got=%h exp=%h", c, mem_addr, (c <= 2) ? 16'h0004 : 16'h0005); end
      end
      if (c == 5) begin
        checks++; if (inst_valid !== 1'b1 || instruction !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misaligned_data got=%b/%h exp=1/%h", inst_valid, instruction, 32'hDEAD_BEEF); end
      end
      @(posedge clk); #1;
      req = 1'b0;
    end
    $display("misaligned: pc=%h instruction=%h", 32'hB, instruction);
  endtask

  task automatic test_wait0();
    logic [3:0]  exp_f;
    logic [15:0] exp_ad;
    req0 = 1'b1; pc0 = 32'h0000_0010;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      exp_f  = {(c <= 2) ? 1'b1 : 1'b0, (c == 1 || c == 2) ? 1'b1 : 1'b0, (c == 3) ? 1'b1 : 1'b0, 1'b0};
      exp_ad = (c == 1) ? 16'h0008 : (c == 2) ? 16'h0009 : 16'h0000;
      checks++; if ({freeze0, mem_rd0, inst_valid0, 1'b0} !== exp_f) begin errors++; $display("FAIL wait0_flags cyc=%0d got=%b exp=%b", c, {freeze0, mem_rd0, inst_valid0}, exp_f[3:1]); end
      checks++; if (mem_addr0 !== exp_ad) begin errors++; $display("FAIL wait0_addr cyc=%0d got=%h exp=%h", c, mem_addr0, exp_ad); end
      if (c == 3) begin
        checks++; if (instruction0 !== 32'h2222_1111) begin errors++; $display("FAIL wait0_data got=%h exp=%h", instruction0, 32'h2222_1111); end
      end
      @(posedge clk); #1;
      req0 = 1'b0;
    end
    $display("wait0: pc=%h instruction=%h", 32'h10, instruction0);
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; flush = 1'b0; pc = '0;
    req0 = 1'b0; flush0 = 1'b0; pc0 = '0;
    test_reset();
    test_miss();
    test_buffer();
    test_flush();
    test_reset_mid();
    test_misaligned();
    test_wait0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
